// File: rtl/pc_next_predict_if.sv
// ============================================================================
// Module : pc_next_predict_if
// Brief  : Pipeline-side signal bundle of the next-PC / BTB predictor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_next_predict_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              id_jump;
    logic [ADDR_W-1:0] id_jump_dst;
    logic              ex_br_valid;
    logic [ADDR_W-1:0] ex_br_pc;
    logic              ex_br_taken;
    logic [ADDR_W-1:0] ex_br_dst;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_dst;
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_dst;
    logic              flush_if;
    logic              flush_id;

    modport master (
        output stall, id_jump, id_jump_dst,
        output ex_br_valid, ex_br_pc, ex_br_taken, ex_br_dst,
        output ex_pred_taken, ex_pred_dst,
        input  pc, pred_taken, pred_dst, flush_if, flush_id
    );

    modport slave (
        input  stall, id_jump, id_jump_dst,
        input  ex_br_valid, ex_br_pc, ex_br_taken, ex_br_dst,
        input  ex_pred_taken, ex_pred_dst,
        output pc, pred_taken, pred_dst, flush_if, flush_id
    );
endinterface

`default_nettype wire

// File: rtl/pc_next_predict.sv
// ============================================================================
// Module : pc_next_predict
// Brief  : Fetch PC register with direct-mapped BTB (tag/target/2-bit counter).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_next_predict #(
    parameter int               ADDR_W   = 32,
    parameter int               ENTRIES  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [1:0]       CTR_INIT = 2'b01
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    pc_next_predict_if.slave     bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] C_FOUR = ADDR_W'(4);

    logic [ADDR_W-1:0]  r_pc;
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_pred_taken;
    logic [ADDR_W-1:0] w_pred_dst;

    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_hit;
    logic [1:0]        w_ex_ctr;
    logic [1:0]        w_ctr_inc;
    logic [1:0]        w_ctr_dec;
    logic              w_mispredict;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [ADDR_W-1:0] w_next_pc;

    // IF lookup on the current fetch PC; reads see pre-update contents
    assign w_idx        = r_pc[IDX_W+1:2];
    assign w_tag        = r_pc[ADDR_W-1:IDX_W+2];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pred_taken = w_hit && r_ctr[w_idx][1];
    assign w_pred_dst   = w_pred_taken ? r_target[w_idx] : (r_pc + C_FOUR);

    assign w_ex_idx  = bus.ex_br_pc[IDX_W+1:2];
    assign w_ex_tag  = bus.ex_br_pc[ADDR_W-1:IDX_W+2];
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_ex_ctr  = r_ctr[w_ex_idx];
    assign w_ctr_inc = (w_ex_ctr == 2'b11) ? 2'b11 : (w_ex_ctr + 2'b01);
    assign w_ctr_dec = (w_ex_ctr == 2'b00) ? 2'b00 : (w_ex_ctr - 2'b01);

    assign w_mispredict  = bus.ex_br_valid &&
                           ((bus.ex_br_taken != bus.ex_pred_taken) ||
                            (bus.ex_br_taken && (bus.ex_br_dst != bus.ex_pred_dst)));
    assign w_redirect_pc = bus.ex_br_taken ? bus.ex_br_dst : (bus.ex_br_pc + C_FOUR);

    always_comb begin
        w_next_pc = w_pred_dst;
        if (w_mispredict) begin
            w_next_pc = w_redirect_pc;
        end else if (bus.stall) begin
            w_next_pc = r_pc;
        end else if (bus.id_jump) begin
            w_next_pc = bus.id_jump_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else begin
            r_pc <= w_next_pc;
            if (bus.ex_br_valid) begin
                if (w_ex_hit) begin
                    r_ctr[w_ex_idx] <= bus.ex_br_taken ? w_ctr_inc : w_ctr_dec;
                end else if (bus.ex_br_taken) begin
                    r_valid[w_ex_idx] <= 1'b1;
                    r_ctr[w_ex_idx]   <= 2'b10;
                end
            end
        end
    end

    // Tag/target are qualified by r_valid, so they need no reset
    always_ff @(posedge clk) begin
        if (bus.ex_br_valid && bus.ex_br_taken) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= bus.ex_br_dst;
        end
    end

    assign bus.pc         = r_pc;
    assign bus.pred_taken = w_pred_taken;
    assign bus.pred_dst   = w_pred_dst;
    assign bus.flush_id   = w_mispredict;
    assign bus.flush_if   = w_mispredict || (bus.id_jump && !bus.stall);

endmodule

`default_nettype wire

// File: tb/tb_pc_next_predict.sv
// ============================================================================
// Module : tb_pc_next_predict
// Brief  : Directed vector bench for pc_next_predict (ENTRIES=16, RESET_PC=0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_next_predict;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pc_next_predict_if #(.ADDR_W(32)) bus ();

    pc_next_predict #(
        .ADDR_W   (32),
        .ENTRIES  (16),
        .RESET_PC (32'h0),
        .CTR_INIT (2'b01)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        st;
        logic        jp;
        logic [31:0] jd;
        logic        bv;
        logic [31:0] bpc;
        logic        bt;
        logic [31:0] bd;
        logic        ept;
        logic [31:0] epd;
        logic [31:0] x_pc;
        logic        x_pt;
        logic [31:0] x_pd;
        logic        x_fi;
        logic        x_fd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic jp, input logic [31:0] jd,
                                input logic bv, input logic [31:0] bpc, input logic bt,
                                input logic [31:0] bd, input logic ept, input logic [31:0] epd,
                                input logic [31:0] x_pc, input logic x_pt, input logic [31:0] x_pd,
                                input logic x_fi, input logic x_fd);
        vec_t v;
        v.st = st; v.jp = jp; v.jd = jd; v.bv = bv; v.bpc = bpc; v.bt = bt; v.bd = bd;
        v.ept = ept; v.epd = epd; v.x_pc = x_pc; v.x_pt = x_pt; v.x_pd = x_pd;
        v.x_fi = x_fi; v.x_fd = x_fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic jp, input logic [31:0] jd,
                         input logic bv, input logic [31:0] bpc, input logic bt,
                         input logic [31:0] bd, input logic ept, input logic [31:0] epd);
        bus.stall = st; bus.id_jump = jp; bus.id_jump_dst = jd;
        bus.ex_br_valid = bv; bus.ex_br_pc = bpc; bus.ex_br_taken = bt;
        bus.ex_br_dst = bd; bus.ex_pred_taken = ept; bus.ex_pred_dst = epd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] x_pc, input logic x_pt,
                           input logic [31:0] x_pd, input logic x_fi, input logic x_fd);
        chk({tag, ".pc"},         bus.pc, x_pc);
        chk({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(x_pt));
        chk({tag, ".pred_dst"},   bus.pred_dst, x_pd);
        chk({tag, ".flush_if"},   32'(bus.flush_if), 32'(x_fi));
        chk({tag, ".flush_id"},   32'(bus.flush_id), 32'(x_fd));
    endtask

    initial begin
        //          st jp jd            bv bpc       bt bd            ept epd          pc            pt pd            fi fd
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h4,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h4,   0, 32'h8,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h8,   0, 32'hC,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'hC,   0, 32'h10,  0, 0));
        // learn 0x40 -> 0x100 via mispredict
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h40, 1, 32'h100, 0, 32'h0,   32'h10,  0, 32'h14,  1, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h40,  1, 32'h100, 0, 0));
        // correct taken resolve: ctr 2 -> 3
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h40, 1, 32'h100, 1, 32'h100, 32'h100, 0, 32'h104, 0, 0));
        // not taken: ctr 3 -> 2, redirect 0x44
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h40, 0, 32'h0,   1, 32'h100, 32'h104, 0, 32'h108, 1, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h44,  0, 32'h48,  1, 0));
        // ctr=2 still predicts; same-cycle not-taken resolve sees old ctr
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h40, 0, 32'h0,   1, 32'h100, 32'h40,  1, 32'h100, 1, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h44,  0, 32'h48,  1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h40,  0, 32'h44,  0, 0));
        // priority: mispredict beats stall and ID jump
        vecs.push_back(mk(1, 1, 32'h200, 1, 32'h7C, 0, 32'h0,   1, 32'h90,  32'h44,  0, 32'h48,  1, 1));
        // stall holds pc and suppresses the jump
        vecs.push_back(mk(1, 1, 32'h300, 0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h80,  0, 32'h84,  0, 0));
        vecs.push_back(mk(1, 1, 32'h300, 0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h80,  0, 32'h84,  0, 0));
        vecs.push_back(mk(0, 1, 32'h300, 0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h80,  0, 32'h84,  1, 0));
        // alias: 0x80 replaces 0x40 in idx 0
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h80, 1, 32'h180, 0, 32'h0,   32'h300, 0, 32'h304, 1, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h180, 0, 32'h184, 1, 0));
        vecs.push_back(mk(0, 1, 32'h80,  0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h40,  0, 32'h44,  1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h80,  1, 32'h180, 0, 0));
        // wrap at top of address space
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h180, 0, 32'h184, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'hFFFFFFFC, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h4,   0, 0));

        idle();
        repeat (2) @(negedge clk);
        chk_out("reset", 32'h0, 0, 32'h4, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].jp, vecs[i].jd, vecs[i].bv, vecs[i].bpc,
                  vecs[i].bt, vecs[i].bd, vecs[i].ept, vecs[i].epd);
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].x_pc, vecs[i].x_pt, vecs[i].x_pd,
                    vecs[i].x_fi, vecs[i].x_fd);
            @(negedge clk);
        end

        // asynchronous reset mid-operation clears pc without a clock edge
        idle();
        #1;
        chk("pre_reset.pc", bus.pc, 32'h4);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset.pc", bus.pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // learned entry for 0x80 must be gone after reset
        drive(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
        #1 chk_out("post_rst_jump", 32'h0, 0, 32'h4, 1, 0);
        @(negedge clk);
        // BTB updates while stalled; lookup of same idx still sees old contents
        drive(1, 0, 0, 1, 32'h200, 1, 32'h400, 1, 32'h400);
        #1 chk_out("stall_update", 32'h80, 0, 32'h84, 0, 0);
        @(negedge clk);
        drive(0, 1, 32'h200, 0, 0, 0, 0, 0, 0);
        #1 chk_out("jump_200", 32'h80, 0, 32'h84, 1, 0);
        @(negedge clk);
        idle();
        #1 chk_out("hit_200", 32'h200, 1, 32'h400, 0, 0);
        @(negedge clk);
        #1 chk("follow_pred.pc", bus.pc, 32'h400);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
